pixel_pipe: RTL

PIXEL_PIPE -- requirements
Module: pixel_pipe

---
 rtl/pixel_pipe_if.sv | 30 +++
 rtl/pixel_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_pipe_if
//  Description : VRAM read handshake between pixel_pipe (master) and the
//                video memory arbiter (slave). Data is valid with ack.
//  Revision    : 1.0  initial release
// ============================================================================
interface pixel_pipe_if #(
    parameter int ADDR_W = 13
);
    logic              vram_req;
    logic [ADDR_W-1:0] vram_addr;
    logic              vram_ack;
    logic [7:0]        vram_data;

    modport master (
        output vram_req,
        output vram_addr,
        input  vram_ack,
        input  vram_data
    );

    modport slave (
        input  vram_req,
        input  vram_addr,
        output vram_ack,
        output vram_data
    );
endinterface
`default_nettype wire

// File: rtl/pixel_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_pipe
//  Description : Per-line VRAM byte prefetch into a small FIFO, MSB-first
//                1/2/4 bpp serializer with horizontal repeat, 16-entry
//                palette and registered RGB output with border override.
//  Revision    : 1.0  initial release
// ============================================================================
module pixel_pipe #(
    parameter int ADDR_W     = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              pixel_clock,
    input  logic              reset,
    input  logic              line_start,
    input  logic [ADDR_W-1:0] line_base,
    input  logic [7:0]        line_bytes,
    input  logic [1:0]        bpp_sel,
    input  logic [2:0]        h_rep,
    input  logic              active,
    input  logic              show_border,
    input  logic [23:0]       border_rgb,
    pixel_pipe_if.master      vram,
    input  logic              pal_we,
    input  logic [3:0]        pal_waddr,
    input  logic [23:0]       pal_wdata,
    output logic [23:0]       vga_rgb,
    output logic              underrun,
    input  logic              underrun_clr
);

    localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);
    localparam logic [23:0]        c_PAL_INIT [16] = '{
        24'h07ff00, 24'hffff00, 24'h3b08ff, 24'hcc003b,
        24'hffffff, 24'h07e399, 24'hff1cff, 24'hff8100,
        24'h000000, 24'h000000, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000
    };

    // fetch side
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic              r_stale;       // outstanding request belongs to a flushed line
    logic [ADDR_W-1:0] r_pend_base;   // new line base waiting for the stale ack
    logic [7:0]        r_remaining;

    // prefetch FIFO
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;

    // serializer
    logic [7:0]  r_shift;
    logic [3:0]  r_pix_left;          // 0 means the shifter is empty
    logic [2:0]  r_rep;
    logic [1:0]  r_bpp;               // 0 = 1bpp, 1 = 2bpp, 2 = 4bpp
    logic [2:0]  r_hrep;

    logic        r_underrun;
    logic [23:0] r_rgb;
    logic [23:0] r_pal [16];

    logic               w_ack;
    logic               w_hold;
    logic               w_push;
    logic               w_pop;
    logic               w_run;
    logic               w_need;
    logic               w_starve;
    logic               w_fifo_empty;
    logic [7:0]         w_head;
    logic [7:0]         w_cur;
    logic [7:0]         w_cur_shifted;
    logic [3:0]         w_ppb;
    logic [3:0]         w_cur_left;
    logic [3:0]         w_idx;
    logic [c_CNT_W-1:0] w_count_next;
    logic [7:0]         w_remaining_next;
    logic               w_req_next;

    assign w_ack        = r_req & vram.vram_ack;
    assign w_hold       = r_req & ~vram.vram_ack;
    // a byte acked in the line_start cycle belongs to the old line and is dropped
    assign w_push       = w_ack & ~r_stale & ~line_start;
    assign w_run        = active & ~line_start;
    assign w_fifo_empty = (r_count == '0);
    assign w_head       = r_mem[r_rptr];
    assign w_need       = (r_pix_left == 4'd0);
    assign w_starve     = w_run & w_need & w_fifo_empty;
    assign w_pop        = w_run & w_need & ~w_fifo_empty;
    // a freshly needed byte is used straight from the FIFO head in the same cycle
    assign w_cur        = w_need ? w_head : r_shift;
    assign w_cur_left   = w_need ? w_ppb : r_pix_left;

    // pixel width decode: index extraction, shift step and pixels per byte
    always_comb begin
        w_ppb         = 4'd4;
        w_idx         = {2'b00, w_cur[7:6]};
        w_cur_shifted = {w_cur[5:0], 2'b00};
        case (r_bpp)
            2'd0: begin
                w_ppb         = 4'd8;
                w_idx         = {3'b000, w_cur[7]};
                w_cur_shifted = {w_cur[6:0], 1'b0};
            end
            2'd2: begin
                w_ppb         = 4'd2;
                w_idx         = w_cur[7:4];
                w_cur_shifted = {w_cur[3:0], 4'h0};
            end
            default: ;
        endcase
        if (w_starve) begin
            w_idx = 4'd0;
        end
    end

    assign w_count_next     = line_start ? '0
                            : r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    assign w_remaining_next = line_start ? line_bytes : r_remaining - {7'd0, w_push};
    // a held request stays up; otherwise request only when a slot is free
    assign w_req_next       = w_hold | ((w_remaining_next != 8'd0) && (w_count_next < c_DEPTH));

    assign vram.vram_req  = r_req;
    assign vram.vram_addr = r_addr;
    assign vga_rgb        = r_rgb;
    assign underrun       = r_underrun;

    // request / address / remaining-count tracking, including the stale-ack flush
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            r_req       <= 1'b0;
            r_addr      <= '0;
            r_stale     <= 1'b0;
            r_pend_base <= '0;
            r_remaining <= 8'd0;
        end else begin
            r_req       <= w_req_next;
            r_remaining <= w_remaining_next;
            if (line_start) begin
                r_pend_base <= line_base;
                r_stale     <= w_hold;
                if (!w_hold) begin
                    r_addr <= line_base;
                end
            end else if (w_ack) begin
                r_stale <= 1'b0;
                r_addr  <= r_stale ? r_pend_base : r_addr + 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; line_start flushes
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
            if (line_start) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // FIFO storage needs no reset; occupancy guards every read
    always_ff @(posedge pixel_clock) begin
        if (w_push) begin
            r_mem[r_wptr] <= vram.vram_data;
        end
    end

    // serializer position: advances only while active and fed
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            r_shift    <= 8'd0;
            r_pix_left <= 4'd0;
            r_rep      <= 3'd0;
            r_bpp      <= 2'd0;
            r_hrep     <= 3'd0;
        end else if (line_start) begin
            r_shift    <= 8'd0;
            r_pix_left <= 4'd0;
            r_rep      <= 3'd0;
            r_bpp      <= (bpp_sel == 2'd3) ? 2'd1 : bpp_sel;
            r_hrep     <= h_rep;
        end else if (w_run && !w_starve) begin
            if (r_rep == r_hrep) begin
                r_rep      <= 3'd0;
                r_shift    <= w_cur_shifted;
                r_pix_left <= w_cur_left - 4'd1;
            end else begin
                r_rep      <= r_rep + 3'd1;
                r_shift    <= w_cur;
                r_pix_left <= w_cur_left;
            end
        end
    end

    // sticky underrun; a new starvation wins over a clear
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= (r_underrun & ~underrun_clr) | w_starve;
        end
    end

    // palette register file; reads in the write cycle see the old entry
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                r_pal[i] <= c_PAL_INIT[i];
            end
        end else if (pal_we) begin
            r_pal[pal_waddr] <= pal_wdata;
        end
    end

    // output colour: border, then palette, then black
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            r_rgb <= 24'h000000;
        end else if (show_border) begin
            r_rgb <= border_rgb;
        end else if (active) begin
            r_rgb <= r_pal[w_idx];
        end else begin
            r_rgb <= 24'h000000;
        end
    end

endmodule
`default_nettype wire
